// File: rtl/branch_control_2bc_pkg.sv
// Shared types for the branch_control_2bc predictor: 2-bit counter states and
// address-width constants.
package branch_control_2bc_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/branch_control_2bc_bp_meta_reg.sv
// Load/flush pipeline register carrying branch-prediction metadata between stages.
module bp_meta_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/branch_control_2bc.sv
// Direct-mapped BTB with 2-bit saturating counters, predicting in IF and resolving in EX.
// Optional gshare counter indexing is enabled by defining BP_GSHARE_EN.
module branch_control_2bc
    import branch_control_2bc_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int GHR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              do_jump,
    input  logic              is_ujump,
    input  logic              br_en,
    input  logic [ADDR_W-1:0] true_addr,
    input  logic [ADDR_W-1:0] pc_idex,
    input  logic              load_ifid,
    input  logic              load_idex,
    input  logic              ifid_rst,
    input  logic              idex_rst,
    output logic [ADDR_W-1:0] pred_addr,
    output logic [ADDR_W-1:0] recv_addr,
    output logic              br_hazard
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [IDX_W-1:0]  cidx;
        logic              hit;
        logic              pred_taken;
        logic [ADDR_W-1:0] pred_target;
        logic [GHR_W-1:0]  ghr;
    } bp_meta_t;

    function automatic bp_ctr_t ctr_inc(input bp_ctr_t c);
        return (c == ST) ? ST : bp_ctr_t'(c + 2'd1);
    endfunction

    function automatic bp_ctr_t ctr_dec(input bp_ctr_t c);
        return (c == SNT) ? SNT : bp_ctr_t'(c - 2'd1);
    endfunction

    logic              valid_q  [NUM_SETS];
    logic [TAG_W-1:0]  tag_q    [NUM_SETS];
    logic [ADDR_W-1:0] target_q [NUM_SETS];
    bp_ctr_t           ctr_q    [NUM_SETS];
    logic [GHR_W-1:0]  ghr_q;

    // IF: combinational lookup
    logic [IDX_W-1:0] idx_p0, cidx_p0;
    logic [TAG_W-1:0] tag_p0;
    logic             hit_p0, pred_taken_p0;
    bp_meta_t         meta_p0, meta_p1, meta_p2;

    assign idx_p0 = pc[IDX_W+1:2];
    assign tag_p0 = pc[ADDR_W-1:IDX_W+2];
`ifdef BP_GSHARE_EN
    assign cidx_p0 = idx_p0 ^ IDX_W'(ghr_q);
`else
    assign cidx_p0 = idx_p0;
    assign ghr_q   = '0;
`endif
    assign hit_p0        = valid_q[idx_p0] && (tag_q[idx_p0] == tag_p0);
    assign pred_taken_p0 = hit_p0 && ctr_q[cidx_p0][1];
    assign pred_addr     = pred_taken_p0 ? target_q[idx_p0] : pc + INSTR_BYTES;

    assign meta_p0 = '{idx: idx_p0, cidx: cidx_p0, hit: hit_p0, pred_taken: pred_taken_p0,
                       pred_target: target_q[idx_p0], ghr: ghr_q};

    // IF/ID and ID/EX metadata registers
    bp_meta_reg #(.WIDTH($bits(bp_meta_t))) u_meta_ifid (
        .clk(clk), .rst(rst), .flush(ifid_rst), .load(load_ifid), .d(meta_p0), .q(meta_p1)
    );
    bp_meta_reg #(.WIDTH($bits(bp_meta_t))) u_meta_idex (
        .clk(clk), .rst(rst), .flush(idex_rst), .load(load_idex), .d(meta_p1), .q(meta_p2)
    );

    // EX: resolution against the actual outcome
    logic       taken;
    logic       ctr_we, tgt_we, alloc_we, inval_we;
    bp_ctr_t    ctr_wdata;
    logic [TAG_W-1:0] tag_ex;
    logic       unused_bits;

    assign taken       = is_ujump | br_en;
    assign tag_ex      = pc_idex[ADDR_W-1:IDX_W+2];
    assign unused_bits = ^{pc[1:0], meta_p2.ghr};

    always_comb begin
        br_hazard = 1'b0;
        recv_addr = true_addr;
        ctr_we    = 1'b0;
        ctr_wdata = ctr_q[meta_p2.cidx];
        tgt_we    = 1'b0;
        alloc_we  = 1'b0;
        inval_we  = 1'b0;
        if (do_jump && taken) begin
            br_hazard = !meta_p2.pred_taken || (meta_p2.pred_target != true_addr);
            ctr_we    = 1'b1;
            if (meta_p2.hit) begin
                ctr_wdata = ctr_inc(ctr_q[meta_p2.cidx]);
                tgt_we    = (target_q[meta_p2.idx] != true_addr);
            end else begin
                ctr_wdata = is_ujump ? ST : WT;
                tgt_we    = 1'b1;
                alloc_we  = 1'b1;
            end
        end else if (do_jump) begin
            br_hazard = meta_p2.pred_taken;
            recv_addr = meta_p2.pred_taken ? pc_idex + INSTR_BYTES : true_addr;
            ctr_we    = meta_p2.hit;
            ctr_wdata = ctr_dec(ctr_q[meta_p2.cidx]);
        end else if (meta_p2.pred_taken) begin
            br_hazard = 1'b1;
            recv_addr = pc_idex + INSTR_BYTES;
            inval_we  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
        end else if (load_idex) begin
            if (ctr_we)   ctr_q[meta_p2.cidx]   <= ctr_wdata;
            if (tgt_we)   target_q[meta_p2.idx] <= true_addr;
            if (alloc_we) begin
                valid_q[meta_p2.idx] <= 1'b1;
                tag_q[meta_p2.idx]   <= tag_ex;
            end
            if (inval_we) valid_q[meta_p2.idx] <= 1'b0;
        end
    end

`ifdef BP_GSHARE_EN
    // Global history advances once per resolved branch/jump
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (load_idex && do_jump) begin
            ghr_q <= GHR_W'({ghr_q, taken});
        end
    end
`endif

endmodule
